// File: rtl/booth_dot_seq.sv
// Dot-product sequencer around the iterative 7x7 signed Booth multiplier.
// Feeds operand pairs to the multiplier one at a time and accumulates the products.
module booth_dot_seq #(
  parameter int unsigned DW      = 7,
  parameter int unsigned PW      = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [DW-1:0]    mul_a,
  output logic [DW-1:0]    mul_b,
  input  logic [PW-1:0]    mul_y,
  input  logic             mul_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned      TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            last_q;
  logic [TW-1:0]   timer;

  logic            take;
  logic            capture;
  logic            timeout;
  logic            clear;
  logic            timer_clr;
  logic            timer_inc;

  logic [ACC_W-1:0] y_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             ovf_now;

  // Product sign-extended to the accumulator and the wrapped sum
  assign y_ext   = ACC_W'($signed(mul_y));
  assign acc_sum = out_acc + y_ext;
  assign ovf_now = (out_acc[ACC_W-1] == y_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != out_acc[ACC_W-1]);

  // Next-state and control strobes
  always_comb begin
    state_next = state;
    take       = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    clear      = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          take       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        timer_inc = 1'b1;
        // A product arriving on the final timer cycle still counts
        if (mul_valid) begin
          capture    = 1'b1;
          state_next = last_q ? DONE : IDLE;
        end else if (timer == TIMER_LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          clear      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with state-decoded outputs registered alongside
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      mul_start <= (state_next == ISSUE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand hold registers: the multiplier re-reads them every iteration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      last_q <= 1'b0;
    end else if (take) begin
      mul_a  <= in_a;
      mul_b  <= in_b;
      last_q <= in_last;
    end
  end

  // Wait timer for the multiplier response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (timer_inc) begin
      timer <= timer + TW'(1);
    end
  end

  // Accumulator, element count and sticky status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (clear) begin
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (capture) begin
        out_acc <= acc_sum;
        out_ovf <= out_ovf | ovf_now;
        if (out_count != CNT_MAX) begin
          out_count <= out_count + CNT_W'(1);
        end
      end
      if (timeout) begin
        out_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_dot_seq.sv
// Bench for booth_dot_seq: behavioural multiplier model plus a result scoreboard.
`timescale 1ns/1ps
module tb_booth_dot_seq;

  localparam int unsigned DW      = 7;
  localparam int unsigned PW      = 16;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int          ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int          ACC_MIN = -(1 << (ACC_W - 1));
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_a = '0;
  logic [DW-1:0]    in_b = '0;
  logic             in_last = 1'b0;
  logic             mul_start;
  logic [DW-1:0]    mul_a;
  logic [DW-1:0]    mul_b;
  logic [PW-1:0]    mul_y = '0;
  logic             mul_valid = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_err;
  logic             busy;

  always #5 clk = ~clk;

  booth_dot_seq #(
    .DW(DW), .PW(PW), .ACC_W(ACC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
    .out_ovf(out_ovf), .out_err(out_err), .busy(busy)
  );

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: product valid for one cycle, lat cycles after the start pulse
  int            lat      = 9;
  bit            model_on = 1'b1;
  int            mcnt     = 0;
  int            n_start  = 0;
  logic [DW-1:0] a_lat, b_lat;

  always @(negedge clk) begin
    mul_valid = 1'b0;
    if (mul_start) begin
      n_start++;
      if (model_on) begin
        mcnt  = lat;
        a_lat = mul_a;
        b_lat = mul_b;
        mul_y = PW'(int'($signed(mul_a)) * int'($signed(mul_b)));
      end
    end else if (mcnt != 0) begin
      if (busy) begin
        check("mul_a_hold", 64'(mul_a), 64'(a_lat));
        check("mul_b_hold", 64'(mul_b), 64'(b_lat));
      end
      mcnt--;
      if (mcnt == 0) mul_valid = 1'b1;
    end
  end

  // Reference accumulator kept as an unbounded int, range-checked for overflow
  int e_acc = 0;
  int e_cnt = 0;
  bit e_ovf = 1'b0;

  task automatic model_reset();
    e_acc = 0;
    e_cnt = 0;
    e_ovf = 1'b0;
  endtask

  task automatic model_add(input int a, input int b);
    int               s;
    logic [ACC_W-1:0] t;
    s = e_acc + a * b;
    if (s > ACC_MAX || s < ACC_MIN) e_ovf = 1'b1;
    t     = ACC_W'(s);
    e_acc = int'($signed(t));
    if (e_cnt < CNT_SAT) e_cnt++;
  endtask

  task automatic push(input bit err);
    exp_t e;
    e.acc = ACC_W'(e_acc);
    e.cnt = CNT_W'(e_cnt);
    e.ovf = e_ovf;
    e.err = err;
    sb.push_back(e);
    model_reset();
  endtask

  // Present one pair and return at the negedge after it was taken
  task automatic send(input int a, input int b, input bit last, output int t_acc);
    int k = 0;
    in_valid = 1'b1;
    in_a     = DW'(a);
    in_b     = DW'(b);
    in_last  = last;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    t_acc    = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic elem(input int a, input int b, input bit last, output int t_acc);
    send(a, b, last, t_acc);
    model_add(a, b);
    if (last) push(1'b0);
  endtask

  // Wait for a result, hold it back for 'hold' cycles, then accept and compare
  task automatic collect(input int hold, input int exp_lat);
    int   k = 0;
    exp_t e;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("out_valid", 64'(out_valid), 64'(1));
    check("latency", 64'(k), 64'(exp_lat));
    check("in_ready_done", 64'(in_ready), 64'(0));
    check("sb_size", 64'(sb.size()), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("frozen", 64'({out_acc, out_count, out_ovf, out_err, out_valid, in_ready}),
              64'({e.acc, e.cnt, e.ovf, e.err, 1'b1, 1'b0}));
      end
      check("out_acc", 64'(out_acc), 64'(e.acc));
      check("out_count", 64'(out_count), 64'(e.cnt));
      check("out_ovf", 64'(out_ovf), 64'(e.ovf));
      check("out_err", 64'(out_err), 64'(e.err));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", 64'(in_ready), 64'(1));
    check("out_valid_after", 64'(out_valid), 64'(0));
    check("acc_cleared", 64'(out_acc), 64'(0));
  endtask

  initial begin
    int t0, t1, t2;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_mul_start", 64'(mul_start), 64'(0));
    check("rst_out_acc", 64'(out_acc), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single pair
    n_start = 0;
    elem(3, -5, 1'b1, t0);
    collect(3, 10);
    check("start_pulses", 64'(n_start), 64'(1));

    // Three-element vector with back-to-back source
    elem(3, 4, 1'b0, t0);
    elem(-2, 5, 1'b0, t1);
    elem(-64, -64, 1'b1, t2);
    check("period_1", 64'(t1 - t0), 64'(11));
    check("period_2", 64'(t2 - t1), 64'(11));
    collect(0, 10);

    // Output backpressure, then a fresh vector
    elem(-7, 6, 1'b1, t0);
    collect(20, 10);
    elem(1, 1, 1'b1, t0);
    collect(0, 10);

    // Accumulator overflow
    for (int i = 0; i < 8; i++) elem(-64, -64, i == 7, t0);
    collect(0, 10);

    // Multiplier never answers
    model_on = 1'b0;
    send(4, 4, 1'b1, t0);
    push(1'b1);
    collect(2, 16);
    model_on = 1'b1;

    // Product arriving on the last timer cycle is accepted
    lat = TIMEOUT;
    elem(3, 3, 1'b1, t0);
    collect(0, 16);
    lat = 9;

    // Element counter saturation
    for (int i = 0; i < 17; i++) elem(1, 1, i == 16, t0);
    collect(0, 10);

    // Reset in the middle of the second element's wait
    send(5, 5, 1'b0, t0);
    send(7, 7, 1'b0, t0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_acc", 64'(out_acc), 64'(0));
    check("mid_rst_count", 64'(out_count), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_mul_a", 64'({mul_a, mul_b}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    check("late_valid_acc", 64'(out_acc), 64'(0));
    check("late_valid_count", 64'(out_count), 64'(0));
    check("late_valid_busy", 64'(busy), 64'(0));
    elem(2, 3, 1'b1, t0);
    collect(0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/booth_dot_seq.md
Name: booth_dot_seq

Overview:
- Sequencer directly upstream and downstream of the iterative 7x7 signed Booth multiplier.
- Accepts a stream of signed operand pairs through a valid/ready handshake and issues one multiply per pair.
- Holds the operands stable while the multiplier iterates, then collects each 16-bit product.
- Accumulates the products into a signed dot-product and presents the result through an output handshake.

Parameters:
- DW, 7, operand width (must match multiplier A/B width).
- PW, 16, product width (must match multiplier Y width).
- ACC_W, 24, accumulator width; must satisfy ACC_W >= PW.
- CNT_W, 4, element-counter width.
- TIMEOUT, 15, max cycles waited for mul_valid after mul_start before declaring an error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  DW  signed operand A.
- in_b  in  DW  signed operand B.
- in_last  in  1  pair is the final element of the vector.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  DW  multiplier operand A, held stable.
- mul_b  out  DW  multiplier operand B, held stable.
- mul_y  in  PW  signed product from the multiplier.
- mul_valid  in  1  one-cycle product-valid pulse from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  signed accumulated dot-product.
- out_count  out  CNT_W  number of products accumulated.
- out_ovf  out  1  sticky signed overflow of the accumulator.
- out_err  out  1  timeout occurred.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all of the following are 0: acc, count, ovf, err, timer, mul_a, mul_b, mul_start, out_valid. in_ready=1 after reset. A reset mid-operation abandons the vector with no output; any later mul_valid is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a->mul_a, in_b->mul_b, and in_last->last_q; go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly this cycle; timer cleared; go to WAIT.
  - in_ready=0.
- WAIT:
  - in_ready=0; mul_a/mul_b stay unchanged, because the multiplier re-reads A every iteration.
  - timer increments each cycle.
  - On mul_valid:
    - acc <= acc + sext(mul_y) (wrap-around two's complement).
    - ovf is set if the operand signs are equal and the result sign differs.
    - count saturates at 2^CNT_W-1.
    - Next state is DONE if last_q=1, otherwise IDLE.
  - If timer reaches TIMEOUT without mul_valid: err<=1, go to DONE with no accumulate.
  - If mul_valid arrives in the same cycle the timer reaches TIMEOUT, mul_valid wins (accumulate, no err).
- DONE:
  - out_valid=1; out_acc, out_count, out_ovf, and out_err are stable while out_valid=1 && out_ready=0.
  - On out_ready: clear acc, count, ovf, and err; go to IDLE. in_ready rises the following cycle.
  - There is no same-cycle bypass from output to input.
- mul_valid seen in IDLE, ISSUE, or DONE is ignored.
- in_valid while in_ready=0: the pair is not taken; the source must hold it.
- Latency per element: accept cycle + ISSUE + multiplier latency (9 cycles from start to valid) + 1 capture. For the last element, out_valid asserts the cycle after the capturing mul_valid.
- Throughput is one pair per 11 cycles with a zero-wait source.
- busy = (state != IDLE).

Test Plan:
- Single pair, last=1: (3, -5) -> one mul_start pulse, then out_acc=-15, out_count=1, ovf=0, err=0. out_valid is held until out_ready.
- Three-element vector: (3,4), (-2,5), (-64,-64) with last on the third -> out_acc=4098, out_count=3. mul_a/mul_b stay constant across each WAIT window.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stay frozen and in_ready=0. After out_ready=1, a new vector (1,1) gives out_acc=1, proving the accumulator cleared.
- Overflow with ACC_W=16: eight pairs of (-64,-64) -> out_acc=-32768 (0x8000), out_ovf=1, out_count=8.
- Timeout: multiplier model never asserts mul_valid -> after TIMEOUT=15 WAIT cycles, out_valid=1, out_err=1, out_acc=0, out_count=0.
- Reset mid-WAIT: rst low for 1 cycle during the 2nd element -> all outputs return to 0 and in_ready=1. A late mul_valid causes no accumulate. A following vector (2,3) gives out_acc=6.
